// File: rtl/alu_operand_fetch.sv
// rtl/alu_operand_fetch.sv - operand fetch/issue stage with pending scoreboard and writeback bypass
module alu_operand_fetch #(
  parameter int DW    = 16,
  parameter int NREGS = 8,
  parameter int RW    = 3
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [2:0]    i_op,
  input  logic [RW-1:0] i_rd,
  input  logic [RW-1:0] i_rs1,
  input  logic [RW-1:0] i_rs2,
  input  logic          i_use_imm,
  input  logic [DW-1:0] i_imm,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_a,
  output logic [DW-1:0] o_b,
  output logic [2:0]    o_op,
  output logic [RW-1:0] o_rd,
  input  logic          i_wb_en,
  input  logic [RW-1:0] i_wb_rd,
  input  logic [DW-1:0] i_wb_data
);

  logic [DW-1:0]    regs [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;
  logic [NREGS-1:0] blocked;
  logic [DW-1:0]    fwd_a;
  logic [DW-1:0]    fwd_b;
  logic             hazard;
  logic             accept;

  // Source read with r0 forced to zero and a same-cycle bypass from writeback
  always_comb begin
    fwd_a = regs[i_rs1];
    fwd_b = regs[i_rs2];
    if (i_wb_en && (i_wb_rd == i_rs1)) fwd_a = i_wb_data;
    if (i_wb_en && (i_wb_rd == i_rs2)) fwd_b = i_wb_data;
    if (i_rs1 == '0) fwd_a = '0;
    if (i_rs2 == '0) fwd_b = '0;
  end

  // A register is blocked while pending, unless this cycle's writeback releases it
  always_comb begin
    blocked = '0;
    for (int r = 0; r < NREGS; r++) begin
      blocked[r] = pending[r] && !(i_wb_en && (i_wb_rd == RW'(r)));
    end
  end

  // RAW on either source (rs2 only when it is actually read) and WAW on a non-zero rd
  always_comb begin
    hazard = blocked[i_rs1]
          || (!i_use_imm && blocked[i_rs2])
          || ((i_rd != '0) && blocked[i_rd]);
  end

  assign o_ready = (!o_valid || i_ready) && !hazard;
  assign accept  = i_valid && o_ready;

  // Next scoreboard: writeback clears first so a same-cycle issue to that register wins
  always_comb begin
    pending_nxt = pending;
    if (i_wb_en) pending_nxt[i_wb_rd] = 1'b0;
    if (accept && (i_rd != '0)) pending_nxt[i_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Register file; writeback lands even on pending registers, r0 is never written
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (i_wb_en && (i_wb_rd != '0)) begin
      regs[i_wb_rd] <= i_wb_data;
    end
  end

  // Output stage: load on accept, drop valid when drained, otherwise hold
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_a     <= '0;
      o_b     <= '0;
      o_op    <= '0;
      o_rd    <= '0;
    end else if (accept) begin
      o_valid <= 1'b1;
      o_a     <= fwd_a;
      o_b     <= i_use_imm ? i_imm : fwd_b;
      o_op    <= i_op;
      o_rd    <= i_rd;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_fetch.sv
// tb/tb_alu_operand_fetch.sv - scoreboard testbench for alu_operand_fetch
module tb_alu_operand_fetch;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [2:0]  i_op = '0;
  logic [2:0]  i_rd = '0;
  logic [2:0]  i_rs1 = '0;
  logic [2:0]  i_rs2 = '0;
  logic        i_use_imm = 1'b0;
  logic [15:0] i_imm = '0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [15:0] o_a;
  logic [15:0] o_b;
  logic [2:0]  o_op;
  logic [2:0]  o_rd;
  logic        i_wb_en = 1'b0;
  logic [2:0]  i_wb_rd = '0;
  logic [15:0] i_wb_data = '0;

  alu_operand_fetch dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_use_imm(i_use_imm), .i_imm(i_imm), .o_valid(o_valid), .i_ready(i_ready),
    .o_a(o_a), .o_b(o_b), .o_op(o_op), .o_rd(o_rd),
    .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [2:0]  rd;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_regs [8];
  bit          m_pend [8];
  bit          m_ovalid;
  bit          done = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < 8; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 0;
    end
    m_ovalid = 0;
    exp_q.delete();
  endfunction

  // One clock of stimulus; the model decides readiness, expected outputs and next state
  task automatic cycle(input bit v, input logic [2:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2, input bit ui,
                       input logic [15:0] imm, input bit rdy, input bit we,
                       input logic [2:0] wrd, input logic [15:0] wdata);
    bit          b1, b2, bd, haz, ready_exp, acc;
    logic [15:0] va, vb;
    exp_t        e;
    @(posedge i_clk);
    #1;
    i_valid = v; i_op = op; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2;
    i_use_imm = ui; i_imm = imm; i_ready = rdy;
    i_wb_en = we; i_wb_rd = wrd; i_wb_data = wdata;
    #4;
    b1 = m_pend[rs1] && !(we && wrd == rs1);
    b2 = m_pend[rs2] && !(we && wrd == rs2);
    bd = m_pend[rd]  && !(we && wrd == rd);
    haz = b1 || (!ui && b2) || (rd != 0 && bd);
    ready_exp = (!m_ovalid || rdy) && !haz;
    check("o_ready", {31'b0, o_ready}, {31'b0, ready_exp});
    acc = v && ready_exp;
    va = (rs1 == 0) ? 16'h0 : ((we && wrd == rs1) ? wdata : m_regs[rs1]);
    vb = ui ? imm : ((rs2 == 0) ? 16'h0 : ((we && wrd == rs2) ? wdata : m_regs[rs2]));
    if (acc) begin
      e.a = va; e.b = vb; e.op = op; e.rd = rd;
      exp_q.push_back(e);
    end
    m_ovalid = acc ? 1 : (rdy ? 0 : m_ovalid);
    if (we) m_pend[wrd] = 0;
    if (acc && rd != 0) m_pend[rd] = 1;
    if (we && wrd != 0) m_regs[wrd] = wdata;
  endtask

  task automatic idle(input bit rdy);
    cycle(0, 3'd0, 3'd0, 3'd0, 3'd0, 1, 16'h0, rdy, 0, 3'd0, 16'h0);
  endtask

  // Monitor: compares the presented output against the queue head and retires it on transfer
  initial begin
    exp_t h;
    while (!done) begin
      @(posedge i_clk);
      #3;
      if (i_rst_n) begin
        if (o_valid) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_valid got=1 want=0 at %0t", $time);
          end else begin
            h = exp_q[0];
            check("o_a",  {16'b0, o_a},  {16'b0, h.a});
            check("o_b",  {16'b0, o_b},  {16'b0, h.b});
            check("o_op", {29'b0, o_op}, {29'b0, h.op});
            check("o_rd", {29'b0, o_rd}, {29'b0, h.rd});
            if (i_ready) void'(exp_q.pop_front());
          end
        end else if (exp_q.size() != 0) begin
          checks++; errors++;
          $display("FAIL missing_valid got=0 want=1 at %0t", $time);
        end
      end
    end
  end

  // Asynchronous reset mid-cycle, with rs1=3 presented so readiness reflects cleared pending bits
  task automatic do_reset();
    @(posedge i_clk);
    #1;
    i_valid = 0; i_rs1 = 3'd3; i_rs2 = 3'd0; i_rd = 3'd0; i_use_imm = 1;
    i_wb_en = 0; i_ready = 1;
    i_rst_n = 0;
    #1;
    check("rst_o_valid", {31'b0, o_valid}, 32'd0);
    check("rst_o_a", {16'b0, o_a}, 32'd0);
    check("rst_o_b", {16'b0, o_b}, 32'd0);
    check("rst_o_op", {29'b0, o_op}, 32'd0);
    check("rst_o_rd", {29'b0, o_rd}, 32'd0);
    model_reset();
    i_rst_n = 1;
    #1;
    check("rst_o_ready", {31'b0, o_ready}, 32'd1);
  endtask

  initial begin
    model_reset();
    #2;
    i_rst_n = 0;
    #10;
    i_rst_n = 1;
    idle(1);

    // writeback then read r1
    cycle(0, 3'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0, 1, 1, 3'd1, 16'h1234);
    cycle(1, 3'd1, 3'd4, 3'd1, 3'd0, 0, 16'h0, 1, 0, 3'd0, 16'h0);
    idle(1);
    // same-cycle bypass with immediate
    cycle(1, 3'd2, 3'd5, 3'd2, 3'd0, 1, 16'h0005, 1, 1, 3'd2, 16'hBEEF);
    idle(1);
    // RAW stall released by writeback in the accept cycle
    cycle(1, 3'd3, 3'd3, 3'd1, 3'd0, 1, 16'h0, 1, 0, 3'd0, 16'h0);
    cycle(1, 3'd4, 3'd0, 3'd3, 3'd0, 1, 16'h0, 1, 0, 3'd0, 16'h0);
    cycle(1, 3'd4, 3'd0, 3'd3, 3'd0, 1, 16'h0, 1, 0, 3'd0, 16'h0);
    cycle(1, 3'd4, 3'd0, 3'd3, 3'd0, 1, 16'h0, 1, 1, 3'd3, 16'h00AA);
    check("pend3_clear", {31'b0, m_pend[3]}, 32'd0);
    idle(1);
    // backpressure: three stalled cycles with a waiting instruction
    cycle(1, 3'd5, 3'd6, 3'd0, 3'd0, 1, 16'h1111, 0, 0, 3'd0, 16'h0);
    for (int k = 0; k < 3; k++) cycle(1, 3'd6, 3'd7, 3'd0, 3'd0, 1, 16'h2222, 0, 0, 3'd0, 16'h0);
    cycle(1, 3'd6, 3'd7, 3'd0, 3'd0, 1, 16'h2222, 1, 0, 3'd0, 16'h0);
    idle(1);
    // r0 writes ignored and never pending
    cycle(1, 3'd7, 3'd0, 3'd0, 3'd0, 1, 16'h0, 1, 1, 3'd0, 16'hFFFF);
    check("r0_first_ready", {31'b0, o_ready}, 32'd1);
    cycle(1, 3'd7, 3'd0, 3'd0, 3'd0, 0, 16'h0, 1, 0, 3'd0, 16'h0);
    check("r0_second_ready", {31'b0, o_ready}, 32'd1);
    idle(1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 1), 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
            $urandom_range(0, 1), 16'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 1), 3'($urandom), 16'($urandom));
    end

    // drain pending bits, then leave o_valid=1 and r3 pending across a reset
    for (int r = 1; r < 8; r++) cycle(0, 3'd0, 3'd0, 3'd0, 3'd0, 1, 16'h0, 1, 1, 3'(r), 16'(r * 3));
    cycle(1, 3'd2, 3'd3, 3'd1, 3'd0, 1, 16'h0, 1, 0, 3'd0, 16'h0);
    idle(0);
    check("pre_reset_valid", {31'b0, o_valid}, 32'd1);
    do_reset();
    cycle(1, 3'd1, 3'd0, 3'd3, 3'd0, 1, 16'h0007, 1, 0, 3'd0, 16'h0);
    idle(1);
    idle(1);

    done = 1;
    @(posedge i_clk);
    #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
